alu_sequencer: RTL and testbench

//  Request/response front end that drives the 16-bit Hack ALU, which is instantiated beside it.
//  - Decodes a 5-bit opcode into the zx,nx,zy,ny,f,no control bits.
//  - Single-pass ops: presents operands, registers out/zr/ng, returns them over a valid/ready response.
//  - Optionally sequences a 16-cycle shift-add multiply through the ALU's x+y path.

---
 rtl/alu_sequencer_if.sv | 42 ++++
 rtl/alu_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request/response/ALU-side bundle for alu_sequencer.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
// Ports (signals):
//   req_valid/req_ready/req_op/req_x/req_y   request channel
//   rsp_valid/rsp_ready/rsp_out/rsp_zr/rsp_ng/rsp_err   response channel
//   alu_x/alu_y/alu_ctl -> ALU, alu_out/alu_zr/alu_ng <- ALU
// Modports: slave = the sequencer's view, master = requester + ALU side.
interface alu_sequencer_if #(
    parameter int W   = 16,
    parameter int OPW = 5
);
    logic           req_valid;
    logic           req_ready;
    logic [OPW-1:0] req_op;
    logic [W-1:0]   req_x;
    logic [W-1:0]   req_y;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_out;
    logic           rsp_zr;
    logic           rsp_ng;
    logic           rsp_err;

    logic [W-1:0]   alu_x;
    logic [W-1:0]   alu_y;
    logic [5:0]     alu_ctl;
    logic [W-1:0]   alu_out;
    logic           alu_zr;
    logic           alu_ng;

    modport slave (
        input  req_valid, req_op, req_x, req_y, rsp_ready, alu_out, alu_zr, alu_ng,
        output req_ready, rsp_valid, rsp_out, rsp_zr, rsp_ng, rsp_err, alu_x, alu_y, alu_ctl
    );

    modport master (
        output req_valid, req_op, req_x, req_y, rsp_ready, alu_out, alu_zr, alu_ng,
        input  req_ready, rsp_valid, rsp_out, rsp_zr, rsp_ng, rsp_err, alu_x, alu_y, alu_ctl
    );
endinterface

// File: rtl/alu_sequencer.sv
// Front end for the 16-bit Hack ALU: decodes opcodes, runs one ALU pass (or a 16-step multiply), returns a registered response.
// Latency: illegal op 1 cycle, single-pass op 2 cycles, multiply 17 cycles (accept edge to rsp_valid).
// Backpressure: one request in flight; req_ready only in IDLE, response held stable until rsp_ready.
// Ports: clk (rising edge), reset (async, active-high), bus (alu_sequencer_if.slave: req_*, rsp_*, alu_*).
// Build option: define ALU_SEQ_MUL_EN to make opcode 18 a shift-add multiply (x*y mod 2^16);
// without it the multiply datapath is not built and opcode 18 is treated as illegal.
module alu_sequencer #(
    parameter int W   = 16,
    parameter int OPW = 5
) (
    input  logic               clk,
    input  logic               reset,
    alu_sequencer_if.slave     bus
);

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

    localparam logic [5:0] CTL_ZERO = 6'b101010;
    localparam logic [5:0] CTL_ADD  = 6'b000010;

    // Returns {legal, zx,nx,zy,ny,f,no}.
    function automatic logic [6:0] decode(input logic [OPW-1:0] op);
        case (op)
            5'd0:    decode = {1'b1, 6'b101010};
            5'd1:    decode = {1'b1, 6'b111111};
            5'd2:    decode = {1'b1, 6'b111010};
            5'd3:    decode = {1'b1, 6'b001100};
            5'd4:    decode = {1'b1, 6'b110000};
            5'd5:    decode = {1'b1, 6'b001101};
            5'd6:    decode = {1'b1, 6'b110001};
            5'd7:    decode = {1'b1, 6'b001111};
            5'd8:    decode = {1'b1, 6'b110011};
            5'd9:    decode = {1'b1, 6'b011111};
            5'd10:   decode = {1'b1, 6'b110111};
            5'd11:   decode = {1'b1, 6'b001110};
            5'd12:   decode = {1'b1, 6'b110010};
            5'd13:   decode = {1'b1, 6'b000010};
            5'd14:   decode = {1'b1, 6'b010011};
            5'd15:   decode = {1'b1, 6'b000111};
            5'd16:   decode = {1'b1, 6'b000000};
            5'd17:   decode = {1'b1, 6'b010101};
`ifdef ALU_SEQ_MUL_EN
            5'd18:   decode = {1'b1, CTL_ADD};
`endif
            default: decode = {1'b0, CTL_ZERO};
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   y_q, y_d;

    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_out_q, rsp_out_d;
    logic           rsp_zr_q, rsp_zr_d;
    logic           rsp_ng_q, rsp_ng_d;
    logic           rsp_err_q, rsp_err_d;

    logic [6:0]     dec_req;
    logic [6:0]     dec_op;

`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   mc_q, mc_d;
    logic [W-1:0]   mp_q, mp_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [W-1:0]   acc_nx;
`endif

    assign bus.req_ready = (state_q == IDLE) && !reset;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_zr    = rsp_zr_q;
    assign bus.rsp_ng    = rsp_ng_q;
    assign bus.rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        rsp_valid_d = rsp_valid_q;
        rsp_out_d   = rsp_out_q;
        rsp_zr_d    = rsp_zr_q;
        rsp_ng_d    = rsp_ng_q;
        rsp_err_d   = rsp_err_q;
        bus.alu_x   = '0;
        bus.alu_y   = '0;
        bus.alu_ctl = CTL_ZERO;
        dec_req     = decode(bus.req_op);
        dec_op      = decode(op_q);
`ifdef ALU_SEQ_MUL_EN
        acc_d       = acc_q;
        mc_d        = mc_q;
        mp_d        = mp_q;
        cnt_d       = cnt_q;
        acc_nx      = acc_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    op_d = bus.req_op;
                    x_d  = bus.req_x;
                    y_d  = bus.req_y;
`ifdef ALU_SEQ_MUL_EN
                    if (bus.req_op == 5'd18) begin
                        state_d = MUL;
                        acc_d   = '0;
                        mc_d    = bus.req_x;
                        mp_d    = bus.req_y;
                        cnt_d   = '0;
                    end else
`endif
                    if (dec_req[6]) begin
                        state_d = EXEC;
                    end else begin
                        // Illegal opcode: answer immediately with an all-zero result.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_out_d   = '0;
                        rsp_zr_d    = 1'b1;
                        rsp_ng_d    = 1'b0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end

            EXEC: begin
                bus.alu_x   = x_q;
                bus.alu_y   = y_q;
                bus.alu_ctl = dec_op[5:0];
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_out_d   = bus.alu_out;
                rsp_zr_d    = bus.alu_zr;
                rsp_ng_d    = bus.alu_ng;
                rsp_err_d   = 1'b0;
            end

`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                // One shift-add step per cycle; the ALU computes acc + mc.
                bus.alu_x   = acc_q;
                bus.alu_y   = mc_q;
                bus.alu_ctl = CTL_ADD;
                acc_nx      = mp_q[0] ? bus.alu_out : acc_q;
                acc_d       = acc_nx;
                mc_d        = mc_q << 1;
                mp_d        = mp_q >> 1;
                cnt_d       = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_out_d   = acc_nx;
                    rsp_zr_d    = (acc_nx == '0);
                    rsp_ng_d    = acc_nx[W-1];
                    rsp_err_d   = 1'b0;
                end
            end
`endif

            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= '0;
            rsp_zr_q    <= 1'b0;
            rsp_ng_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            rsp_zr_q    <= rsp_zr_d;
            rsp_ng_q    <= rsp_ng_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            mc_q  <= '0;
            mp_q  <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            mc_q  <= mc_d;
            mp_q  <= mp_d;
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed cases plus randomized ops with random response backpressure.
// Latency: n/a.
// Backpressure: rsp_ready is stalled in directed bursts and randomly in the random phase.
module tb_alu_sequencer;

    logic clk;
    logic reset;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural Hack ALU placed beside the sequencer.
    logic [15:0] hx, hy, hr;
    always_comb begin
        hx = bus.alu_ctl[5] ? 16'h0000 : bus.alu_x;
        if (bus.alu_ctl[4]) hx = ~hx;
        hy = bus.alu_ctl[3] ? 16'h0000 : bus.alu_y;
        if (bus.alu_ctl[2]) hy = ~hy;
        hr = bus.alu_ctl[1] ? (hx + hy) : (hx & hy);
        if (bus.alu_ctl[0]) hr = ~hr;
    end
    assign bus.alu_out = hr;
    assign bus.alu_zr  = (hr == 16'h0000);
    assign bus.alu_ng  = hr[15];

    typedef struct {
        logic [15:0] out;
        logic        zr;
        logic        ng;
        logic        err;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int stall_cnt = 0;
    bit bp_en = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: result of each opcode written directly as arithmetic on x and y.
    function automatic exp_t model(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        logic [15:0] r;
        bit          ok;
        ok = 1'b1;
        r  = 16'h0000;
        case (op)
            5'd0:  r = 16'h0000;
            5'd1:  r = 16'h0001;
            5'd2:  r = 16'hFFFF;
            5'd3:  r = x;
            5'd4:  r = y;
            5'd5:  r = ~x;
            5'd6:  r = ~y;
            5'd7:  r = -x;
            5'd8:  r = -y;
            5'd9:  r = x + 16'd1;
            5'd10: r = y + 16'd1;
            5'd11: r = x - 16'd1;
            5'd12: r = y - 16'd1;
            5'd13: r = x + y;
            5'd14: r = x - y;
            5'd15: r = y - x;
            5'd16: r = x & y;
            5'd17: r = x | y;
`ifdef ALU_SEQ_MUL_EN
            5'd18: r = x * y;
`endif
            default: ok = 1'b0;
        endcase
        e.err     = !ok;
        e.out     = ok ? r : 16'h0000;
        e.zr      = (e.out == 16'h0000);
        e.ng      = e.out[15];
        e.lat     = !ok ? 1 : ((op == 5'd18) ? 17 : 2);
        e.acc_cyc = 0;
        return e;
    endfunction

    // Stimulus: holds the request until accepted, then pushes the expected response.
    task automatic send(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int   w;
        bus.req_op    = op;
        bus.req_x     = x;
        bus.req_y     = y;
        bus.req_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 200 cycles");
            bus.req_valid = 1'b0;
            return;
        end
        e = model(op, x, y);
        e.acc_cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 400) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Response consumer: directed stalls take priority over random backpressure.
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                bus.rsp_ready = 1'b0;
                stall_cnt--;
            end else if (bp_en) begin
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.rsp_ready = 1'b1;
            end
        end
    end

    // Monitor: pops and checks whenever a response is presented.
    initial begin
        exp_t        e;
        bit          seen;
        bit          hs_prev;
        logic [18:0] held;
        seen    = 1'b0;
        hs_prev = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen    = 1'b0;
                hs_prev = 1'b0;
            end else begin
                if (hs_prev) chk("req_ready_after_handshake", bus.req_ready, 1);
                hs_prev = 1'b0;
                if (bus.rsp_valid) begin
                    chk("req_ready_while_busy", bus.req_ready, 0);
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 out=%0h", bus.rsp_out);
                    end else begin
                        if (!seen) begin
                            e = sb[0];
                            chk("latency", cyc - e.acc_cyc, e.lat);
                            chk("rsp_out", bus.rsp_out, e.out);
                            chk("rsp_zr",  bus.rsp_zr,  e.zr);
                            chk("rsp_ng",  bus.rsp_ng,  e.ng);
                            chk("rsp_err", bus.rsp_err, e.err);
                            held = {bus.rsp_out, bus.rsp_zr, bus.rsp_ng, bus.rsp_err};
                            seen = 1'b1;
                        end else begin
                            chk("rsp_hold", {bus.rsp_out, bus.rsp_zr, bus.rsp_ng, bus.rsp_err}, held);
                        end
                        if (bus.rsp_ready) begin
                            void'(sb.pop_front());
                            seen    = 1'b0;
                            hs_prev = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_out"},   bus.rsp_out,   0);
        chk({tag, "_rsp_zr"},    bus.rsp_zr,    0);
        chk({tag, "_rsp_ng"},    bus.rsp_ng,    0);
        chk({tag, "_rsp_err"},   bus.rsp_err,   0);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_alu_ctl"},   bus.alu_ctl,   6'b101010);
        chk({tag, "_alu_x"},     bus.alu_x,     0);
        chk({tag, "_alu_y"},     bus.alu_y,     0);
    endtask

    initial begin
        logic [4:0] rop;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        #3;
        chk_reset_state("por");
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed single-pass ops and boundaries.
        send(5'd13, 16'h0005, 16'h0003);
        send(5'd14, 16'h0003, 16'h0005);
        send(5'd0,  16'h1234, 16'h5678);
        send(5'd17, 16'h00F0, 16'h0F00);
        send(5'd19, 16'hABCD, 16'h1234);
        send(5'd31, 16'hFFFF, 16'hFFFF);
        send(5'd13, 16'h7FFF, 16'h0001);
        send(5'd9,  16'h7FFF, 16'h0000);
        send(5'd7,  16'h8000, 16'h0000);
        send(5'd18, 16'h0007, 16'h0006);
`ifdef ALU_SEQ_MUL_EN
        send(5'd18, 16'h0100, 16'h0100);
        send(5'd18, 16'hFFFF, 16'h0002);
`endif
        drain();

        // Held response: rsp_ready low for several cycles, then a queued follow-up request.
        stall_cnt = 6;
        send(5'd19, 16'h0001, 16'h0002);
        send(5'd13, 16'h0001, 16'h0002);
        drain();

        // Reset in the middle of a request: no response may follow.
`ifdef ALU_SEQ_MUL_EN
        send(5'd18, 16'h1234, 16'h5678);
        repeat (8) @(posedge clk);
`else
        stall_cnt = 20;
        send(5'd19, 16'h1234, 16'h5678);
        repeat (3) @(posedge clk);
`endif
        #2 reset = 1'b1;
        #1;
        chk_reset_state("midreset");
        sb.delete();
        stall_cnt = 0;
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("req_ready_after_reset", bus.req_ready, 1);
        @(posedge clk);
        #1;
        send(5'd13, 16'h0001, 16'h0001);
        drain();

        // Randomized ops with random backpressure.
        bp_en = 1'b1;
        repeat (150) begin
            rop = 5'($urandom_range(0, 21));
            send(rop, rnd16(), rnd16());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        drain();
        bp_en = 1'b0;
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
